// File: rtl/decode_queue.sv
// Buffered SRM instruction decoder: decodes and evaluates branch conditions on accept, then
// queues the bundle in a DEPTH-entry FIFO. Optional macro DECODE_ILLEGAL_EN adds the illegal output.
module decode_queue #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  in_instr,
  input  logic                         flag_z,
  input  logic                         flag_n,
  input  logic                         flag_v,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2:0]                   opcode,
  output logic [1:0]                   op,
  output logic [2:0]                   rn,
  output logic [2:0]                   rd,
  output logic [2:0]                   rm,
  output logic [1:0]                   shift,
  output logic [W-1:0]                 sximm5,
  output logic [W-1:0]                 sximm8,
  output logic [2:0]                   cond,
  output logic                         take_branch,
`ifdef DECODE_ILLEGAL_EN
  output logic                         illegal,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] shift;
    logic [4:0] imm5;
    logic [7:0] imm8;
    logic [2:0] cond;
    logic       take;
`ifdef DECODE_ILLEGAL_EN
    logic       ill;
`endif
  } entry_t;

  function automatic logic eval_cond(input logic [2:0] c, input logic z, input logic n,
                                     input logic v);
    logic r;
    case (c)
      3'b000:  r = 1'b1;
      3'b001:  r = z;
      3'b010:  r = ~z;
      3'b011:  r = n ^ v;
      3'b100:  r = (n ^ v) | z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic entry_t decode(input logic [15:0] i, input logic z, input logic n,
                                    input logic v);
    entry_t e;
    logic   is_b;
    is_b     = (i[15:13] == 3'b001);
    e.opcode = i[15:13];
    e.op     = i[12:11];
    e.rn     = is_b ? 3'b000 : i[10:8];
    e.rd     = i[7:5];
    e.rm     = i[2:0];
    e.shift  = (i[15:13] == 3'b100) ? 2'b00 : i[4:3];
    e.imm5   = i[4:0];
    e.imm8   = i[7:0];
    e.cond   = is_b ? i[10:8] : 3'b000;
    e.take   = is_b & eval_cond(i[10:8], z, n, v);
`ifdef DECODE_ILLEGAL_EN
    e.ill    = (i[15:13] == 3'b000) | (is_b & (i[10:8] >= 3'b101));
`endif
    return e;
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_s, pop_s;
  entry_t          head_s;

  // in_ready looks only at the held count, so a full queue never accepts even while popping
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != CW'(0));
  assign push_s    = in_valid & in_ready & ~reset;
  assign pop_s     = out_valid & out_ready;
  assign count     = count_q;
  assign head_s    = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Decoded bundle storage, written in the accept cycle
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= decode(in_instr, flag_z, flag_n, flag_v);
    end
  end

  // Head presentation; everything reads as zero while empty
  always_comb begin
    opcode      = 3'b000;
    op          = 2'b00;
    rn          = 3'b000;
    rd          = 3'b000;
    rm          = 3'b000;
    shift       = 2'b00;
    sximm5      = '0;
    sximm8      = '0;
    cond        = 3'b000;
    take_branch = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    illegal     = 1'b0;
`endif
    if (out_valid) begin
      opcode      = head_s.opcode;
      op          = head_s.op;
      rn          = head_s.rn;
      rd          = head_s.rd;
      rm          = head_s.rm;
      shift       = head_s.shift;
      sximm5      = {{(W-5){head_s.imm5[4]}}, head_s.imm5};
      sximm8      = {{(W-8){head_s.imm8[7]}}, head_s.imm8};
      cond        = head_s.cond;
      take_branch = head_s.take;
`ifdef DECODE_ILLEGAL_EN
      illegal     = head_s.ill;
`endif
    end else begin
      take_branch = 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Randomised scoreboard bench for decode_queue: a W=16/DEPTH=2 and a W=32/DEPTH=4 instance
// share the same stimulus and are each checked against a queue-based reference model.
module tb_decode_queue;

  typedef struct {
    int opcode, op, rn, rd, rm, shift, cond, take, ill, imm5, imm8;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, fz, fn, fv, out_ready;
  logic [15:0] in_instr;

  logic        r16, v16, tk16, r32, v32, tk32;
  logic [2:0]  opc16, rn16, rd16, rm16, cnd16, opc32, rn32, rd32, rm32, cnd32;
  logic [1:0]  op16, sh16, op32, sh32;
  logic [15:0] s5_16, s8_16;
  logic [31:0] s5_32, s8_32;
  logic [1:0]  cnt16;
  logic [2:0]  cnt32;
`ifdef DECODE_ILLEGAL_EN
  logic        ill16, ill32;
`endif

  int n_vec = 0;
  int n_bad = 0;
  exp_t q16[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  decode_queue #(.W(16), .DEPTH(2)) dut16 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(r16), .in_instr(in_instr),
    .flag_z(fz), .flag_n(fn), .flag_v(fv), .out_valid(v16), .out_ready(out_ready),
    .opcode(opc16), .op(op16), .rn(rn16), .rd(rd16), .rm(rm16), .shift(sh16),
    .sximm5(s5_16), .sximm8(s8_16), .cond(cnd16), .take_branch(tk16),
`ifdef DECODE_ILLEGAL_EN
    .illegal(ill16),
`endif
    .count(cnt16));

  decode_queue #(.W(32), .DEPTH(4)) dut32 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr),
    .flag_z(fz), .flag_n(fn), .flag_v(fv), .out_valid(v32), .out_ready(out_ready),
    .opcode(opc32), .op(op32), .rn(rn32), .rd(rd32), .rm(rm32), .shift(sh32),
    .sximm5(s5_32), .sximm8(s8_32), .cond(cnd32), .take_branch(tk32),
`ifdef DECODE_ILLEGAL_EN
    .illegal(ill32),
`endif
    .count(cnt32));

  function automatic exp_t ref_decode(input logic [15:0] i, input bit z, input bit n, input bit v);
    exp_t e;
    bit   lt;
    e.opcode = int'(i[15:13]);
    e.op     = int'(i[12:11]);
    e.rd     = int'(i[7:5]);
    e.rm     = int'(i[2:0]);
    e.rn     = (e.opcode == 1) ? 0 : int'(i[10:8]);
    e.cond   = (e.opcode == 1) ? int'(i[10:8]) : 0;
    e.shift  = (e.opcode == 4) ? 0 : int'(i[4:3]);
    e.imm5   = int'(i[4:0]);
    if (e.imm5 >= 16) e.imm5 = e.imm5 - 32;
    e.imm8   = int'(i[7:0]);
    if (e.imm8 >= 128) e.imm8 = e.imm8 - 256;
    lt = (n != v);
    e.take = 0;
    if (e.opcode == 1) begin
      if (e.cond == 0) e.take = 1;
      else if (e.cond == 1) e.take = z ? 1 : 0;
      else if (e.cond == 2) e.take = z ? 0 : 1;
      else if (e.cond == 3) e.take = lt ? 1 : 0;
      else if (e.cond == 4) e.take = (lt || z) ? 1 : 0;
      else e.take = 0;
    end
    e.ill = (e.opcode == 0 || (e.opcode == 1 && e.cond >= 5)) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_bundle(input string tag, input exp_t e, input int w,
                              input logic [2:0] opc, input logic [1:0] op, input logic [2:0] rn,
                              input logic [2:0] rd, input logic [2:0] rm, input logic [1:0] sh,
                              input logic [31:0] s5, input logic [31:0] s8,
                              input logic [2:0] cnd, input logic tk);
    logic [31:0] x5, x8;
    x5 = e.imm5;
    x8 = e.imm8;
    if (w == 16) begin
      x5 = {16'h0000, x5[15:0]};
      x8 = {16'h0000, x8[15:0]};
    end
    chk({tag, ".opcode"}, {29'd0, opc}, e.opcode);
    chk({tag, ".op"},     {30'd0, op},  e.op);
    chk({tag, ".rn"},     {29'd0, rn},  e.rn);
    chk({tag, ".rd"},     {29'd0, rd},  e.rd);
    chk({tag, ".rm"},     {29'd0, rm},  e.rm);
    chk({tag, ".shift"},  {30'd0, sh},  e.shift);
    chk({tag, ".sximm5"}, s5, x5);
    chk({tag, ".sximm8"}, s8, x8);
    chk({tag, ".cond"},   {29'd0, cnd}, e.cond);
    chk({tag, ".take"},   {31'd0, tk},  e.take);
  endtask

  // Reference model: updates expected queue contents on each clock edge
  initial begin
    exp_t e;
    bit   p, o;
    forever begin
      @(posedge clk);
      if (rst) begin
        q16.delete();
        q32.delete();
      end else begin
        e = ref_decode(in_instr, fz, fn, fv);
        p = in_valid && (q16.size() != 2);
        o = out_ready && (q16.size() != 0);
        if (o) void'(q16.pop_front());
        if (p) q16.push_back(e);
        p = in_valid && (q32.size() != 4);
        o = out_ready && (q32.size() != 0);
        if (o) void'(q32.pop_front());
        if (p) q32.push_back(e);
      end
    end
  end

  // Monitor: compares DUT state and head bundle against the model mid-cycle
  initial begin
    exp_t z;
    z = '{default: 0};
    forever begin
      @(negedge clk);
      chk("count16", {30'd0, cnt16}, q16.size());
      chk("in_ready16", {31'd0, r16}, (q16.size() != 2) ? 1 : 0);
      chk("out_valid16", {31'd0, v16}, (q16.size() != 0) ? 1 : 0);
      check_bundle("d16", (q16.size() != 0) ? q16[0] : z, 16, opc16, op16, rn16, rd16, rm16,
                   sh16, {16'h0000, s5_16}, {16'h0000, s8_16}, cnd16, tk16);
      chk("count32", {29'd0, cnt32}, q32.size());
      chk("in_ready32", {31'd0, r32}, (q32.size() != 4) ? 1 : 0);
      chk("out_valid32", {31'd0, v32}, (q32.size() != 0) ? 1 : 0);
      check_bundle("d32", (q32.size() != 0) ? q32[0] : z, 32, opc32, op32, rn32, rd32, rm32,
                   sh32, s5_32, s8_32, cnd32, tk32);
`ifdef DECODE_ILLEGAL_EN
      chk("illegal16", {31'd0, ill16}, (q16.size() != 0) ? q16[0].ill : 0);
      chk("illegal32", {31'd0, ill32}, (q32.size() != 0) ? q32[0].ill : 0);
`endif
    end
  end

  task automatic step(input bit v, input logic [15:0] ins, input bit z, input bit n, input bit vv,
                      input bit ordy, input bit r);
    rst       = r;
    in_valid  = v;
    in_instr  = ins;
    fz        = z;
    fn        = n;
    fv        = vv;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ins;
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000;
    fz = 1'b0; fn = 1'b0; fv = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Directed decode cases
    step(1'b1, 16'hA14B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h815F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h21FE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h21FE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h23FE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h2080, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h26AA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Fill, hold off, drain
    step(1'b1, 16'hA14B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h815F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h6123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h6123, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Steady push+pop
    for (int i = 0; i < 10; i++) step(1'b1, 16'(i * 16'h1357), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // Reset with entries held and a push offered in the reset cycle
    step(1'b1, 16'hC0DE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 2) == 0) ins[15:13] = 3'b001;
      step($urandom_range(0, 3) != 0, ins, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
